// File: rtl/psx_game_input_pkg.sv
// Shared definitions for the PSX pad game-input decoder: button bit positions,
// idle pad values, FSM state encoding and the stick byte un-reversal helper.
package psx_game_input_pkg;

  localparam int BTN_START = 12;
  localparam int BTN_UP    = 11;
  localparam int BTN_DOWN  = 9;
  localparam int BTN_CROSS = 1;

  localparam logic [15:0] IDLE_BUTTONS = 16'hFFFF;
  localparam logic [7:0]  IDLE_STICK   = 8'h80;
  localparam logic [47:0] IDLE_SAMPLE  = {IDLE_BUTTONS, {4{IDLE_STICK}}};

  typedef enum logic [1:0] {
    S_WAIT   = 2'd0,
    S_SAMPLE = 2'd1,
    S_COMMIT = 2'd2,
    S_DECODE = 2'd3
  } state_t;

  function automatic logic [7:0] bit_reverse_byte(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i] = b[7-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/psx_game_input_if.sv
// Pad-side bus: raw poller inputs in, decoded game controls out.
interface psx_game_input_if;
  logic [15:0] button_state;
  logic [31:0] stick_state;
  logic        jump_pulse;
  logic        duck;
  logic        start_pulse;
  logic        pad_valid;
  logic [15:0] buttons;

  modport master (
    output button_state, stick_state,
    input  jump_pulse, duck, start_pulse, pad_valid, buttons
  );

  modport slave (
    input  button_state, stick_state,
    output jump_pulse, duck, start_pulse, pad_valid, buttons
  );
endinterface

// File: rtl/psx_game_input_debounce.sv
// Sampling front end: free-running sample timer, last-sample register and a
// saturating run-length counter that flags the sample completing a stable run.
module psx_game_input_debounce #(
  parameter int unsigned        WIDTH          = 48,
  parameter logic [31:0]        SAMPLE_PERIOD  = 32'd2000,
  parameter logic [3:0]         STABLE_SAMPLES = 4'd3,
  parameter logic [WIDTH-1:0]   IDLE_VALUE     = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_en,
  input  logic [WIDTH-1:0] raw,
  output logic             sample_tick,
  output logic             commit_hit,
  output logic [WIDTH-1:0] last_sample
);

  logic [31:0]      sample_cnt_reg;
  logic [WIDTH-1:0] last_reg;
  logic [3:0]       stable_cnt_reg;
  logic [3:0]       stable_cnt_next;
  logic             raw_matches;

  assign raw_matches = (raw == last_reg);
  assign sample_tick = (sample_cnt_reg == SAMPLE_PERIOD - 32'd1);
  assign last_sample = last_reg;

  always_comb begin
    stable_cnt_next = stable_cnt_reg;
    if (!raw_matches) begin
      stable_cnt_next = 4'd1;
    end else if (stable_cnt_reg < STABLE_SAMPLES) begin
      stable_cnt_next = stable_cnt_reg + 4'd1;
    end
  end

  // Only the sample that lands on the threshold commits; a saturated run stays quiet.
  assign commit_hit = sample_en && (stable_cnt_next == STABLE_SAMPLES) &&
                      (!raw_matches || (stable_cnt_reg != STABLE_SAMPLES));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_cnt_reg <= '0;
      last_reg       <= IDLE_VALUE;
      stable_cnt_reg <= '0;
    end else begin
      sample_cnt_reg <= sample_tick ? 32'd0 : sample_cnt_reg + 32'd1;
      if (sample_en) begin
        stable_cnt_reg <= stable_cnt_next;
        if (!raw_matches) begin
          last_reg <= raw;
        end
      end
    end
  end

endmodule

// File: rtl/psx_game_input.sv
// T-Rex game controls from a free-running PSX pad poller: samples, debounces and
// decodes jump (pulse, with holdoff), duck (level) and start (pulse).
module psx_game_input
  import psx_game_input_pkg::*;
#(
  parameter logic [31:0] SAMPLE_PERIOD  = 32'd2000,
  parameter logic [3:0]  STABLE_SAMPLES = 4'd3,
  parameter logic [31:0] JUMP_HOLDOFF   = 32'd200000,
  parameter logic [7:0]  STICK_LO       = 8'h40,
  parameter logic [7:0]  STICK_HI       = 8'hC0
) (
  input  logic             clk,
  input  logic             rst,
  psx_game_input_if.slave  pad
);

  logic [31:0] stick_unrev;
  logic [47:0] raw_sample;
  logic [47:0] last_sample;
  logic        sample_tick;
  logic        commit_hit;
  logic        unused_sticks;

  // The poller shifts each stick byte in LSB-first; restore normal bit order.
  for (genvar gi = 0; gi < 4; gi++) begin : g_stick
    assign stick_unrev[gi*8 +: 8] = bit_reverse_byte(pad.stick_state[gi*8 +: 8]);
  end

  assign raw_sample = {pad.button_state, stick_unrev};

  state_t      state_reg;
  logic [15:0] committed_buttons_reg;
  logic [7:0]  committed_ly_reg;
  logic        prev_jump_req_reg;
  logic        prev_start_reg;
  logic [31:0] holdoff_reg;
  logic        jump_pulse_reg;
  logic        duck_reg;
  logic        start_pulse_reg;
  logic        pad_valid_reg;
  logic [15:0] buttons_reg;

  psx_game_input_debounce #(
    .WIDTH          (48),
    .SAMPLE_PERIOD  (SAMPLE_PERIOD),
    .STABLE_SAMPLES (STABLE_SAMPLES),
    .IDLE_VALUE     (IDLE_SAMPLE)
  ) u_debounce (
    .clk         (clk),
    .rst         (rst),
    .sample_en   (state_reg == S_SAMPLE),
    .raw         (raw_sample),
    .sample_tick (sample_tick),
    .commit_hit  (commit_hit),
    .last_sample (last_sample)
  );

  // RX/RY/LX are debounced along with everything else but drive no control.
  assign unused_sticks = ^last_sample[31:8];

  logic [15:0] btn_active;
  logic        jump_req;
  logic        duck_req;
  logic        start_req;

  assign btn_active = ~committed_buttons_reg;
  assign jump_req   = btn_active[BTN_CROSS] | btn_active[BTN_UP] | (committed_ly_reg <= STICK_LO);
  assign duck_req   = btn_active[BTN_DOWN] | (committed_ly_reg >= STICK_HI);
  assign start_req  = btn_active[BTN_START];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg             <= S_WAIT;
      committed_buttons_reg <= IDLE_BUTTONS;
      committed_ly_reg      <= IDLE_STICK;
      prev_jump_req_reg     <= 1'b0;
      prev_start_reg        <= 1'b0;
      holdoff_reg           <= '0;
      jump_pulse_reg        <= 1'b0;
      duck_reg              <= 1'b0;
      start_pulse_reg       <= 1'b0;
      pad_valid_reg         <= 1'b0;
      buttons_reg           <= '0;
    end else begin
      jump_pulse_reg  <= 1'b0;
      start_pulse_reg <= 1'b0;
      if (holdoff_reg != 32'd0) begin
        holdoff_reg <= holdoff_reg - 32'd1;
      end

      case (state_reg)
        S_WAIT: begin
          if (sample_tick) begin
            state_reg <= S_SAMPLE;
          end
        end
        S_SAMPLE: begin
          state_reg <= commit_hit ? S_COMMIT : S_WAIT;
        end
        S_COMMIT: begin
          // Edge detection only needs the previous commit's request levels.
          prev_jump_req_reg     <= jump_req;
          prev_start_reg        <= start_req;
          committed_buttons_reg <= last_sample[47:32];
          committed_ly_reg      <= last_sample[7:0];
          pad_valid_reg         <= 1'b1;
          state_reg             <= S_DECODE;
        end
        S_DECODE: begin
          if (jump_req && !prev_jump_req_reg && (holdoff_reg == 32'd0)) begin
            jump_pulse_reg <= 1'b1;
            holdoff_reg    <= JUMP_HOLDOFF;
          end
          start_pulse_reg <= start_req & ~prev_start_reg;
          duck_reg        <= duck_req & ~jump_req;
          buttons_reg     <= btn_active;
          state_reg       <= S_WAIT;
        end
        default: state_reg <= S_WAIT;
      endcase
    end
  end

  assign pad.jump_pulse  = jump_pulse_reg;
  assign pad.duck        = duck_reg;
  assign pad.start_pulse = start_pulse_reg;
  assign pad.pad_valid   = pad_valid_reg;
  assign pad.buttons     = buttons_reg;

endmodule
